// File: rtl/cdc_pkg.sv
// Shared types and defaults for the fast-to-slow pulse stretcher (source side).
package cdc_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PULSE   = 2'd1,
        S_GAP     = 2'd2,
        S_ACK_LOW = 2'd3
    } state_t;

    localparam int DEF_STRETCH = 4;
    localparam int DEF_GAP     = 4;
    localparam int DEF_CNT_W   = 4;

    // Largest value a w-bit unsigned counter can hold.
    function automatic int unsigned sat_val(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/cdc_sat_cnt.sv
// Up/down counter that saturates at its all-ones value and flags a dropped increment.
module cdc_sat_cnt
    import cdc_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         drop
);

    localparam logic [W-1:0] SAT = W'(sat_val(W));

    logic [W-1:0] cnt_reg;

    // Simultaneous inc and dec cancel, so a full counter only drops when no dec arrives.
    always_comb begin
        cnt_next = cnt_reg;
        drop     = 1'b0;
        if (inc && !dec) begin
            if (cnt_reg == SAT) drop = 1'b1;
            else                cnt_next = cnt_reg + W'(1);
        end else if (dec && !inc && cnt_reg != '0) begin
            cnt_next = cnt_reg - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/cdc_pulse_stretch_tx.sv
// Source-domain pulse stretcher: queues clka events and emits STRETCH-wide, GAP-separated pulses.
// Optional handshake mode is enabled by defining CDC_PULSE_STRETCH_ACK_EN (adds ack_in).
module cdc_pulse_stretch_tx
    import cdc_pkg::*;
#(
    parameter int STRETCH = DEF_STRETCH,
    parameter int GAP     = DEF_GAP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clka,
    input  logic             rsta,
`ifdef CDC_PULSE_STRETCH_ACK_EN
    input  logic             ack_in,
`endif
    input  logic             ev_in,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int TMAX = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] STRETCH_LD = TW'(STRETCH - 1);
    localparam logic [TW-1:0] GAP_LD     = TW'(GAP - 1);

    state_t           state_reg, state_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic             pulse_reg, busy_reg, overflow_reg;
    logic             launch, drop;
    logic [CNT_W-1:0] pending_cnt, pending_next;

    cdc_sat_cnt #(.W(CNT_W)) u_pending (
        .clk      (clka),
        .rst_n    (rsta),
        .inc      (ev_in),
        .dec      (launch),
        .cnt      (pending_cnt),
        .cnt_next (pending_next),
        .drop     (drop)
    );

    // timer_reg counts down the remaining cycles of the current PULSE or GAP phase.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        launch     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (pending_cnt != '0) begin
                    launch     = 1'b1;
                    state_next = S_PULSE;
                    timer_next = STRETCH_LD;
                end
            end
            S_PULSE: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end else begin
`ifdef CDC_PULSE_STRETCH_ACK_EN
                    if (ack_in) state_next = S_ACK_LOW;
`else
                    state_next = S_GAP;
                    timer_next = GAP_LD;
`endif
                end
            end
`ifdef CDC_PULSE_STRETCH_ACK_EN
            S_ACK_LOW: begin
                if (!ack_in) begin
                    state_next = S_GAP;
                    timer_next = GAP_LD;
                end
            end
`endif
            S_GAP: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end else if (pending_cnt != '0) begin
                    launch     = 1'b1;
                    state_next = S_PULSE;
                    timer_next = STRETCH_LD;
                end else begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state_reg    <= S_IDLE;
            timer_reg    <= '0;
            pulse_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            pulse_reg    <= (state_next == S_PULSE);
            busy_reg     <= (state_next != S_IDLE) || (pending_next != '0);
            // A drop on the same edge as a clear keeps the flag set.
            overflow_reg <= drop | (overflow_reg & ~clr_ovf);
        end
    end

    assign pulse_out = pulse_reg;
    assign pending   = pending_cnt;
    assign busy      = busy_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cdc_pulse_stretch_tx.sv
// Directed bench for cdc_pulse_stretch_tx (STRETCH=4, GAP=4, CNT_W=2).
module tb_cdc_pulse_stretch_tx;

    logic       clka = 1'b0;
    logic       rsta;
    logic       ev_in;
    logic       clr_ovf;
    logic       pulse_out;
    logic [1:0] pending;
    logic       busy;
    logic       overflow;
`ifdef CDC_PULSE_STRETCH_ACK_EN
    logic       ack_in = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clka = ~clka;

    cdc_pulse_stretch_tx #(.STRETCH(4), .GAP(4), .CNT_W(2)) dut (
        .clka      (clka),
        .rsta      (rsta),
`ifdef CDC_PULSE_STRETCH_ACK_EN
        .ack_in    (ack_in),
`endif
        .ev_in     (ev_in),
        .clr_ovf   (clr_ovf),
        .pulse_out (pulse_out),
        .pending   (pending),
        .busy      (busy),
        .overflow  (overflow)
    );

    typedef struct {
        logic       ev;
        logic       clr;
        logic       p;
        logic [1:0] pend;
        logic       b;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic ev, input logic clr, input logic p,
                       input logic [1:0] pend, input logic b, input logic ov);
        vec_t v;
        v.ev = ev; v.clr = clr; v.p = p; v.pend = pend; v.b = b; v.ov = ov;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic ev, input logic clr);
        @(negedge clka);
        ev_in   = ev;
        clr_ovf = clr;
        @(posedge clka);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk(name, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        int npulse;
        logic prev;

        rsta = 1'b0; ev_in = 1'b0; clr_ovf = 1'b0;
        #1;
        chk("reset_pulse", {7'd0, pulse_out}, 8'd0);
        chk("reset_pending", {6'd0, pending}, 8'd0);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_overflow", {7'd0, overflow}, 8'd0);
        repeat (3) @(posedge clka);
        @(negedge clka);
        rsta = 1'b1;
        repeat (2) step(1'b0, 1'b0);

        // Single event: launch next edge, 4 high, 4 gap, then idle.
        add(1, 1, 0, 0, 1, 1, 0);
        add(4, 0, 0, 1, 0, 1, 0);
        add(4, 0, 0, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0, 0, 0);
        // Burst of three: the second event overlaps the first launch.
        add(1, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(1, 1, 0, 1, 2, 1, 0);
        add(2, 0, 0, 1, 2, 1, 0);
        add(4, 0, 0, 0, 2, 1, 0);
        add(4, 0, 0, 1, 1, 1, 0);
        add(4, 0, 0, 0, 1, 1, 0);
        add(4, 0, 0, 1, 0, 1, 0);
        add(4, 0, 0, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].ev, vecs[i].clr);
            chk($sformatf("vec%0d_pulse", i), {7'd0, pulse_out}, {7'd0, vecs[i].p});
            chk($sformatf("vec%0d_pending", i), {6'd0, pending}, {6'd0, vecs[i].pend});
            chk($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].b});
            chk($sformatf("vec%0d_overflow", i), {7'd0, overflow}, {7'd0, vecs[i].ov});
            $display("vec %0d: ev=%0b clr=%0b -> pulse=%0b pending=%0d busy=%0b ovf=%0b",
                     i, vecs[i].ev, vecs[i].clr, pulse_out, pending, busy, overflow);
        end

        // Overflow: six back-to-back events with a 2-bit counter.
        npulse = 0;
        prev = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step(c < 6, 1'b0);
            if (pulse_out && !prev) npulse++;
            prev = pulse_out;
            if (c == 3) chk("ovf_pending_sat", {6'd0, pending}, 8'd3);
            if (c == 3) chk("ovf_not_yet", {7'd0, overflow}, 8'd0);
            if (c == 4) chk("ovf_set", {7'd0, overflow}, 8'd1);
            if (c == 5) chk("ovf_pending_hold", {6'd0, pending}, 8'd3);
        end
        chk("ovf_pulse_count", 8'(npulse), 8'd4);
        chk("ovf_drained", {6'd0, pending}, 8'd0);
        chk("ovf_sticky", {7'd0, overflow}, 8'd1);
        step(1'b0, 1'b1);
        chk("ovf_clear", {7'd0, overflow}, 8'd0);
        $display("overflow seq: pulses=%0d ovf_after_clr=%0b", npulse, overflow);
        wait_idle("ovf_idle");

        // Drop and clear on the same edge: the set must win.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("coll_pending", {6'd0, pending}, 8'd3);
        step(1'b1, 1'b1);
        chk("coll_set_wins", {7'd0, overflow}, 8'd1);
        step(1'b0, 1'b1);
        chk("coll_clear", {7'd0, overflow}, 8'd0);
        $display("collision seq: ovf=%0b", overflow);
        wait_idle("coll_idle");

        // Asynchronous reset in the second PULSE cycle with two events pending.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_pre_pulse", {7'd0, pulse_out}, 8'd1);
        chk("rst_pre_pending", {6'd0, pending}, 8'd2);
        ev_in = 1'b0;
        rsta  = 1'b0;
        #1;
        chk("rst_async_pulse", {7'd0, pulse_out}, 8'd0);
        chk("rst_async_pending", {6'd0, pending}, 8'd0);
        chk("rst_async_busy", {7'd0, busy}, 8'd0);
        @(negedge clka);
        rsta = 1'b1;
        npulse = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0);
            if (pulse_out || busy) npulse++;
        end
        chk("rst_quiet", 8'(npulse), 8'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_new_event_pulse", {7'd0, pulse_out}, 8'd1);
        $display("reset seq: quiet_cycles_active=%0d new_pulse=%0b", npulse, pulse_out);
        wait_idle("rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
